alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  WIDTH-bit MIPS ALU: single-cycle logic/arith ops plus iterative unsigned multiply/divide into HI/LO.
//  Op encoding keeps the existing 3-bit ALU control in op[2:0]; op[3]=1 selects the multi-cycle unit.
//  Sits in the data path between register-file reads and writeback.
//  The control FSM stalls on busy and samples outputs on done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      operation request; accepted when start=1 and busy=0
//  op        in   4      operation code (see BEHAVIOUR)
//  a         in   WIDTH  operand A (rs)
//  b         in   WIDTH  operand B (rt/imm)
//  busy      out  1      1 while a multiply/divide iterates; start ignored
//  done      out  1      1-cycle pulse: result/hi/lo/flags valid
//  result    out  WIDTH  registered result
//  hi        out  WIDTH  HI register (mul upper word / div remainder)
//  lo        out  WIDTH  LO register (mul lower word / div quotient)
//  zero      out  1      result==0, registered with result
//  overflow  out  1      signed overflow of add/sub, else 0
// BEHAVIOUR
//  Ops: 0000 and, 0001 or, 0010 add, 0110 sub, 0011 xor, 0101 nor, 0111 slt (signed), 1000 multu, 1001 divu.
//  Any other code: result=0, zero=1, overflow=0; takes the 1-cycle path.
//  slt: result = {WIDTH-1 zeros, sign(a-b) XOR ovf(a-b)}. add/sub wrap modulo 2^WIDTH.
//  overflow is set only for add/sub: operands' signs imply the opposite sign of the sum.
//  States: IDLE, MUL, DIV, DONE. Reset -> IDLE; busy=done=overflow=0, result=hi=lo=0, zero=1.
//  Accept: start && !busy, i.e. in IDLE or DONE, so back-to-back 1-cycle ops issue every cycle.
//  1-cycle op accepted at edge t: result/zero/overflow written at edge t; state -> DONE; done=1 in cycle t+1.
//  multu accepted at edge t: latch a,b; clear {hi,lo} accumulator; counter=WIDTH-1; state -> MUL.
//  MUL: one shift-add step per cycle on the 2*WIDTH product; busy=1.
//  MUL ends after exactly WIDTH cycles (counter==0 -> DONE). done in cycle t+WIDTH+1.
//  multu completion: {hi,lo} = a*b, result=lo, overflow=0.
//  divu: restoring division, one quotient bit per cycle, WIDTH cycles, same timing as multu.
//  divu completion: lo=a/b, hi=a%b, result=lo.
//  divu by zero needs no special path: natural result is lo=all ones, hi=a, same latency.
//  DONE: done=1 for exactly one cycle; -> IDLE, or straight into the next accepted op.
//  hi/lo change only on multu/divu completion; intermediate values may be visible while busy.
//  result/zero/overflow hold until the next completion.
//  start while busy: ignored, no queuing. op/a/b may change freely after acceptance.
//  reset mid-operation: abort to IDLE at that edge; all outputs return to reset values; no done pulse.
// TESTING
//  reset; op=0010 a=0x7FFFFFFF b=1 start -> next cycle done=1 result=0x80000000 overflow=1 zero=0.
//  op=0110 a=5 b=5 -> result=0, zero=1. op=0111 a=0xFFFFFFFF b=1 -> result=1 (signed -1<1).
//  op=1000 a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done at t+33, hi=0xFFFFFFFE lo=0x00000001.
//  op=1001 a=100 b=7 -> done at t+33, lo=14 hi=2. Then a=9 b=0 -> lo=0xFFFFFFFF hi=9.
//  During multu pulse start with op=0010 -> ignored; after done, add accepted; hi/lo unchanged.
//  Assert reset at cycle 10 of divu -> next cycle busy=0 done=0 hi=lo=result=0; no later done.

Source files
------------

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - MIPS ALU with single-cycle logic/arith ops and iterative multu/divu into HI/LO.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, result_q;
  logic             busy_q, done_q, zero_q, ovf_q;

  logic [WIDTH-1:0]   sum, diff, alu_res_d;
  logic               add_ovf, sub_ovf, alu_ovf_d;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_sub, div_hi_d, div_lo_d;

  always_comb begin
    sum       = a + b;
    diff      = a - b;
    add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (op)
      OP_AND: alu_res_d = a & b;
      OP_OR:  alu_res_d = a | b;
      OP_ADD: begin
        alu_res_d = sum;
        alu_ovf_d = add_ovf;
      end
      OP_SUB: begin
        alu_res_d = diff;
        alu_ovf_d = sub_ovf;
      end
      OP_XOR: alu_res_d = a ^ b;
      OP_NOR: alu_res_d = ~(a | b);
      OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      default: ;
    endcase

    // Multiplier bits consumed MSB first: acc = 2*acc + bit*a.
    mul_acc_d = {hi_q, lo_q} << 1;
    if (b_q[cnt_q]) begin
      mul_acc_d = mul_acc_d + {{WIDTH{1'b0}}, a_q};
    end

    // Restoring step: remainder lives in HI, quotient shifts into LO.
    div_trial = {hi_q, a_q[cnt_q]};
    div_sub   = div_trial[WIDTH-1:0] - b_q;
    if (div_trial >= {1'b0, b_q}) begin
      div_hi_d = div_sub;
      div_lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_d = div_trial[WIDTH-1:0];
      div_lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        MUL: begin
          {hi_q, lo_q} <= mul_acc_d;
          cnt_q        <= cnt_q - CNT_ONE;
          if (cnt_q == '0) begin
            result_q <= mul_acc_d[WIDTH-1:0];
            zero_q   <= (mul_acc_d[WIDTH-1:0] == '0);
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DIV: begin
          hi_q  <= div_hi_d;
          lo_q  <= div_lo_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == '0) begin
            result_q <= div_lo_d;
            zero_q   <= (div_lo_d == '0);
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept, so single-cycle ops can issue every cycle.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            if (op == OP_MULU || op == OP_DIVU) begin
              a_q     <= a;
              b_q     <= b;
              hi_q    <= '0;
              lo_q    <= '0;
              cnt_q   <= CNT_LAST;
              busy_q  <= 1'b1;
              state_q <= (op == OP_MULU) ? MUL : DIV;
            end else begin
              result_q <= alu_res_d;
              zero_q   <= (alu_res_d == '0);
              ovf_q    <= alu_ovf_d;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result, hi, lo;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_res, exp_hi, exp_lo;
  logic         exp_zero, exp_ovf;
  int           exp_lat;

  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint      s;
    exp_lat = 1;
    exp_ovf = 1'b0;
    case (o)
      4'b0000: exp_res = x & y;
      4'b0001: exp_res = x | y;
      4'b0011: exp_res = x ^ y;
      4'b0101: exp_res = ~(x | y);
      4'b0010: begin
        exp_res = x + y;
        s = longint'($signed(x)) + longint'($signed(y));
        exp_ovf = (s != longint'($signed(exp_res)));
      end
      4'b0110: begin
        exp_res = x - y;
        s = longint'($signed(x)) - longint'($signed(y));
        exp_ovf = (s != longint'($signed(exp_res)));
      end
      4'b0111: exp_res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'b0, x} * {32'b0, y};
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        exp_res = exp_lo;
        exp_lat = W + 1;
      end
      4'b1001: begin
        if (y == 0) begin
          exp_lo = '1;
          exp_hi = x;
        end else begin
          exp_lo = x / y;
          exp_hi = x % y;
        end
        exp_res = exp_lo;
        exp_lat = W + 1;
      end
      default: exp_res = '0;
    endcase
    exp_zero = (exp_res == 0);
  endtask

  // Called just after a rising edge; returns cycles until done (60 = timed out).
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
    start = 1'b1; op = o; a = x; b = y; lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      if (lat == 0) begin
        start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
      end
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, result, hi, lo, zero, overflow} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h hi=%h lo=%h z=%b v=%b want 0 0 0 0 0 1 0",
               busy, done, result, hi, lo, zero, overflow);
    end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed;
    logic [3:0]   ops [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1001};
    logic [W-1:0] as  [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd9};
    logic [W-1:0] bs  [6] = '{32'd1, 32'd5, 32'd1, 32'hFFFFFFFF, 32'd7, 32'd0};
    logic [W-1:0] rs  [6] = '{32'h80000000, 32'h0, 32'h1, 32'h1, 32'd14, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 6; i++) begin
      model(ops[i], as[i], bs[i]);
      run_op(ops[i], as[i], bs[i], lat);
      n_checks++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_lat);
      end
      n_checks++;
      if ({result, hi, lo, zero, overflow} !== {rs[i], exp_hi, exp_lo, exp_zero, exp_ovf}) begin
        n_fail++;
        $display("FAIL directed_out[%0d]: got res=%h hi=%h lo=%h z=%b v=%b want res=%h hi=%h lo=%h z=%b v=%b",
                 i, result, hi, lo, zero, overflow, rs[i], exp_hi, exp_lo, exp_zero, exp_ovf);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy, result} !== {1'b0, 1'b0, rs[i]}) begin
        n_fail++;
        $display("FAIL directed_pulse[%0d]: got done=%b busy=%b res=%h want 0 0 %h", i, done, busy, result, rs[i]);
      end
    end
  endtask

  task automatic test_random_muldiv;
    int lat;
    logic [3:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = (i % 2 == 1) ? 4'b1001 : 4'b1000;
      x = $urandom;
      if (i % 4 == 3)                 y = '0;
      else if ($urandom_range(0, 1)) y = $urandom;
      else                            y = 32'($urandom_range(1, 300));
      model(o, x, y);
      run_op(o, x, y, lat);
      n_checks++;
      if (lat !== exp_lat || {result, hi, lo, zero, overflow} !== {exp_res, exp_hi, exp_lo, exp_zero, exp_ovf}) begin
        n_fail++;
        $display("FAIL muldiv[%0d] op=%b a=%h b=%h: got lat=%0d res=%h hi=%h lo=%h z=%b v=%b want lat=%0d res=%h hi=%h lo=%h z=%b v=%b",
                 i, o, x, y, lat, result, hi, lo, zero, overflow, exp_lat, exp_res, exp_hi, exp_lo, exp_zero, exp_ovf);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]   o;
    logic [W-1:0] x, y;
    logic [W-1:0] edge_vals [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom);
      if (o == 4'b1000 || o == 4'b1001) o = 4'b0100;
      x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      model(o, x, y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy, result, hi, lo, zero, overflow} !== {1'b1, 1'b0, exp_res, exp_hi, exp_lo, exp_zero, exp_ovf}) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h: got done=%b busy=%b res=%h hi=%h lo=%h z=%b v=%b want 1 0 res=%h hi=%h lo=%h z=%b v=%b",
                 i, o, x, y, done, busy, result, hi, lo, zero, overflow, exp_res, exp_hi, exp_lo, exp_zero, exp_ovf);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore;
    int lat, bad_busy;
    logic [W-1:0] x, y;
    x = $urandom; y = $urandom;
    model(4'b1000, x, y);
    start = 1'b1; op = 4'b1000; a = x; b = y;
    lat = 0; bad_busy = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 5);
      op = (lat == 5) ? 4'b0010 : 4'($urandom);
      a = $urandom; b = $urandom;
      if (done) break;
      if (busy !== 1'b1) bad_busy++;
    end
    n_checks++;
    if (lat !== exp_lat || bad_busy != 0 || {result, hi, lo} !== {exp_res, exp_hi, exp_lo}) begin
      n_fail++;
      $display("FAIL busy_ignore: got lat=%0d busy_gaps=%0d res=%h hi=%h lo=%h want lat=%0d 0 res=%h hi=%h lo=%h",
               lat, bad_busy, result, hi, lo, exp_lat, exp_res, exp_hi, exp_lo);
    end
    x = $urandom; y = $urandom;
    model(4'b0010, x, y);
    run_op(4'b0010, x, y, lat);
    n_checks++;
    if (lat !== 1 || {result, hi, lo, zero, overflow} !== {exp_res, exp_hi, exp_lo, exp_zero, exp_ovf}) begin
      n_fail++;
      $display("FAIL add_after_mul: got lat=%0d res=%h hi=%h lo=%h z=%b v=%b want 1 res=%h hi=%h lo=%h z=%b v=%b",
               lat, result, hi, lo, zero, overflow, exp_res, exp_hi, exp_lo, exp_zero, exp_ovf);
    end
  endtask

  task automatic test_reset_mid_div;
    int late_done;
    start = 1'b1; op = 4'b1001; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, result, hi, lo, zero, overflow} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_div: got busy=%b done=%b res=%h hi=%h lo=%h z=%b v=%b want 0 0 0 0 0 1 0",
               busy, done, result, hi, lo, zero, overflow);
    end
    reset = 1'b0;
    late_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) late_done++;
    end
    n_checks++;
    if (late_done != 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d cycles with done/busy, want 0", late_done);
    end
    exp_hi = '0; exp_lo = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_muldiv();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
